// File: rtl/serial_conv_top_if.sv
// Handshake bundle for the serial 3x3 convolution engine.
// The master requests work (en/base); the slave returns the result and a done pulse.
interface serial_conv_top_if;
  logic       en;
  logic [7:0] feature_baseaddr;
  logic       is_done_o;
  logic [7:0] out;

  modport master (
    output en,
    output feature_baseaddr,
    input  is_done_o,
    input  out
  );

  modport slave (
    input  en,
    input  feature_baseaddr,
    output is_done_o,
    output out
  );
endinterface

// File: rtl/serial_conv_top.sv
// Serial 3x3 Gaussian convolution: one MAC per clock over an internal identity feature ROM.
// Optional macro SERIAL_ROUND_EN selects round-half-up with saturation instead of truncation.
module serial_conv_top #(
  parameter int ROW_STRIDE = 4
) (
  input logic             clk,
  input logic             rst,
  serial_conv_top_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  k_reg, k_next;
  logic [15:0] acc_reg, acc_next;
  logic [7:0]  base_reg, base_next;
  logic [7:0]  out_reg, out_next;
  logic        done_reg, done_next;

  logic [7:0]  rom [256];
  logic [7:0]  tap_addr [9];
  logic [7:0]  feature;
  logic [2:0]  weight;
  logic [15:0] product;
  logic [15:0] sum;
  logic [7:0]  result;

  genvar gi;

  generate
    for (gi = 0; gi < 256; gi++) begin : g_rom
      assign rom[gi] = 8'(gi);
    end

    // Per-tap address offsets are constants; the 8-bit add wraps modulo 256.
    for (gi = 0; gi < 9; gi++) begin : g_tap
      localparam logic [7:0] OFFSET = 8'((gi / 3) * ROW_STRIDE + (gi % 3));
      assign tap_addr[gi] = base_reg + OFFSET;
    end
  endgenerate

  assign feature = rom[tap_addr[k_reg]];

  always_comb begin
    weight = 3'd2;
    case (k_reg)
      4'd0, 4'd2, 4'd6, 4'd8: weight = 3'd1;
      4'd4:                   weight = 3'd4;
      default:                weight = 3'd2;
    endcase
  end

  assign product = 16'(feature) * 16'(weight);
  assign sum     = acc_reg + product;

`ifdef SERIAL_ROUND_EN
  logic [15:0] rounded;
  assign rounded = (sum + 16'd8) >> 4;
  assign result  = (rounded > 16'd255) ? 8'hFF : 8'(rounded);
`else
  assign result  = 8'(sum >> 4);
`endif

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    acc_next   = acc_reg;
    base_next  = base_reg;
    out_next   = out_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.en) begin
          base_next  = bus.feature_baseaddr;
          acc_next   = 16'd0;
          k_next     = 4'd0;
          state_next = RUN;
        end
      end
      RUN: begin
        acc_next = sum;
        k_next   = k_reg + 4'd1;
        // The last tap's product goes straight into the result, bypassing the accumulator.
        if (k_reg == 4'd8) begin
          out_next   = result;
          done_next  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      k_reg     <= 4'd0;
      acc_reg   <= 16'd0;
      base_reg  <= 8'd0;
      out_reg   <= 8'd0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      acc_reg   <= acc_next;
      base_reg  <= base_next;
      out_reg   <= out_next;
      done_reg  <= done_next;
    end
  end

  assign bus.out       = out_reg;
  assign bus.is_done_o = done_reg;
endmodule

// File: tb/tb_serial_conv_top.sv
// Directed bench for serial_conv_top: expected results are queued at request time
// and compared when the done pulse arrives.
module tb_serial_conv_top;
  localparam int ROW_STRIDE = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [7:0] sb [$];

  serial_conv_top_if bus ();

  serial_conv_top #(.ROW_STRIDE(ROW_STRIDE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [7:0] b);
    int acc;
    int r;
    logic [7:0] a;
    acc = 0;
    for (int k = 0; k < 9; k++) begin
      a = b + 8'((k / 3) * ROW_STRIDE + (k % 3));
      acc += int'(a) * ((k % 3 == 1) ? 2 : 1) * ((k / 3 == 1) ? 2 : 1);
    end
`ifdef SERIAL_ROUND_EN
    r = (acc + 8) / 16;
    if (r > 255) r = 255;
`else
    r = acc / 16;
`endif
    return 8'(r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; counts rising edges until done is seen.
  task automatic run_txn(input string tag, input logic [7:0] b, input int exp_edges,
                         input int drop_at, input bit glitch);
    int n;
    bit seen;
    logic [7:0] exp_v;
    bus.feature_baseaddr = b;
    bus.en = 1'b1;
    sb.push_back(model(b));
    n = 0;
    seen = 1'b0;
    while (!seen && n < 25) begin
      @(negedge clk);
      n++;
      if (n == drop_at) bus.en = 1'b0;
      if (glitch && n == 4) bus.feature_baseaddr = ~b;
      if (bus.is_done_o === 1'b1) seen = 1'b1;
    end
    check({tag, "_latency"}, seen ? n : 0, exp_edges);
    exp_v = sb.pop_front();
    $display("[TB] txn %s base=0x%02h edges=%0d out=%0d expected=%0d", tag, b, n, bus.out, exp_v);
    check({tag, "_out"}, {24'd0, bus.out}, {24'd0, exp_v});
  endtask

  initial begin
    int done_cnt;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.feature_baseaddr = 8'h00;

    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_out", {24'd0, bus.out}, 32'd0);
    check("reset_done", {31'd0, bus.is_done_o}, 32'd0);
    done_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.is_done_o !== 1'b0) done_cnt++;
    end
    check("idle_no_done", done_cnt, 0);

    // Back-to-back with en held high; each later start waits one DONE and one IDLE edge.
    run_txn("base09", 8'h09, 10, 0, 1'b0);
    check("model09", {24'd0, model(8'h09)}, 32'd14);
    run_txn("base0A", 8'h0A, 11, 0, 1'b0);
    run_txn("base0D", 8'h0D, 11, 0, 1'b0);
    run_txn("base0E", 8'h0E, 11, 0, 1'b0);
    run_txn("baseFE", 8'hFE, 11, 0, 1'b0);
    run_txn("glitch01", 8'h01, 11, 0, 1'b1);

    // en dropped mid-RUN: the computation still completes, then the engine idles.
    run_txn("drop20", 8'h20, 11, 5, 1'b0);
    @(negedge clk);
    check("drop_single_pulse", {31'd0, bus.is_done_o}, 32'd0);
    done_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.is_done_o !== 1'b0) done_cnt++;
    end
    check("drop_idle_no_done", done_cnt, 0);
    check("drop_out_hold", {24'd0, bus.out}, {24'd0, model(8'h20)});

    // Reset mid-RUN aborts the computation.
    bus.feature_baseaddr = 8'h30;
    bus.en = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    bus.en = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_out", {24'd0, bus.out}, 32'd0);
    check("midrst_done", {31'd0, bus.is_done_o}, 32'd0);
    rst = 1'b0;
    done_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.is_done_o !== 1'b0) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);
    check("midrst_out_after", {24'd0, bus.out}, 32'd0);

    run_txn("restart30", 8'h30, 10, 0, 1'b0);
    run_txn("baseFF", 8'hFF, 11, 0, 1'b0);
    bus.en = 1'b0;
    repeat (4) @(negedge clk);
    check("final_out_hold", {24'd0, bus.out}, {24'd0, model(8'hFF)});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_conv_top.md
Name: serial_conv_top

Overview:
- Serial-mode 3x3 convolution engine, one multiply-accumulate (MAC) per clock.
- On start, it latches an 8-bit window base address and reads nine feature bytes from an internal feature ROM.
- Each feature byte is multiplied by a fixed 3x3 Gaussian kernel and summed; the normalised 8-bit result is returned with a one-cycle done pulse.
- It is the top of the serial datapath, the counterpart of the parallel/systolic mode.

Parameters:
- ROW_STRIDE, 4, address distance between window rows (feature map row width).

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  level enable; while high, a new computation starts whenever the engine is idle.
- feature_baseaddr  input  8  address of the window's top-left element; sampled only at start.
- is_done_o  output  1  high for exactly one cycle when out holds a new result.
- out  output  8  registered convolution result; held until the next done.

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high (rst sampled on the clk rising edge).
- Reset values: state=IDLE, out=0, is_done_o=0, accumulator=0, tap counter=0, latched base=0.
- A reset asserted mid-operation aborts the computation; no done pulse follows.
- Feature ROM: 256x8, combinational read, content feature[a] = a (identity). The ROM is internal; no memory ports.
- Kernel: tap k=0..8 in row-major order. Weights are 1,2,1 / 2,4,2 / 1,2,1 (sum 16).
- Tap address: base + (k/3)*ROW_STRIDE + (k%3), computed in 8 bits with modulo-256 wrap.
- Accumulator: 16 bits unsigned; products are unsigned 8x3 bits. The maximum sum is 4080, so there is no overflow.
- FSM states IDLE, RUN, DONE:
  - IDLE: if en=1, latch feature_baseaddr, clear the accumulator, set k=0, go to RUN. Otherwise stay.
  - RUN: each cycle add feature[addr(k)]*w[k] to the accumulator and increment k. On k=8, go to DONE with out <= (acc + last product) >> 4.
  - DONE: is_done_o=1 for this cycle only, then go to IDLE.
- Latency: the start edge is followed by 9 RUN edges. out and is_done_o become valid on the 10th edge after start; the next start is possible 2 edges after that (via IDLE).
- With en held high, computations run back-to-back. feature_baseaddr may change any time after the done cycle and is picked up at the next IDLE.
- en dropping during RUN does not abort; the computation completes and done pulses.
- feature_baseaddr changes during RUN/DONE are ignored (the base stays latched).
- out is only updated on entry to DONE; it otherwise holds its value (including while en=0).

Optional Feature:
- Macro SERIAL_ROUND_EN.
- Defined: out = min(255, (acc + 8) >> 4), i.e. round-half-up with saturation.
- Undefined: out = acc >> 4 (truncation; the result cannot exceed 255).
- Results are identical whenever acc is a multiple of 16.

Test Plan:
- Reset held 100 ns, then release -> out=0, is_done_o=0, no activity while en=0.
- en=1, base=0x09 -> is_done_o pulses once 10 cycles after start, out=14 (0x0E).
- After done, base=0x0A with en still high -> next done gives out=15; then base=0x0D -> out=18; then base=0x0E -> out=19.
- base=0xFE -> addresses wrap mod 256 -> out = truncated weighted sum >> 4 per the model (check against a reference model).
- Drop en mid-RUN -> done still pulses with the correct value; the engine then stays IDLE and out holds.
- Assert rst mid-RUN -> no done pulse, out=0; a restart after release produces the correct result.
